// File: rtl/hp_cvtws_seq.sv
// rtl/hp_cvtws_seq.sv - multi-cycle bfloat16 to signed integer converter, round-to-nearest-even
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   operand handshake; in_ready high only while idle
//   in                  float operand {sign, exp, frac}
//   out_valid/out_ready result handshake
//   out                 signed INTn-bit result (saturated when out of range)
//   inexact             result differs from the exact value
//   invalid             NaN, infinity or out-of-range input
module hp_cvtws_seq #(
  parameter int INTn = 32,
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NEXP+NSIG:0]     in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INTn-1:0]        out,
  output logic                   inexact,
  output logic                   invalid
);

  localparam int EW = NEXP + 2;
  localparam logic signed [EW-1:0] BIAS_W = EW'((2 ** (NEXP - 1)) - 1);
  localparam logic signed [EW-1:0] NSIG_W = EW'(NSIG);
  localparam logic signed [EW-1:0] E_SAT  = EW'(INTn - 1);
  localparam logic signed [EW-1:0] E_LO   = -EW'(2);
  localparam logic [INTn-1:0] INT_MAX = {1'b0, {(INTn-1){1'b1}}};
  localparam logic [INTn-1:0] INT_MIN = {1'b1, {(INTn-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, CLASSIFY, ALIGN, ROUND, DONE} state_t;
  state_t state, state_nxt;

  logic            sign_r;
  logic [NEXP-1:0] exp_r;
  logic [NSIG-1:0] frac_r;
  logic [INTn-1:0] mag;
  logic            guard, sticky;
  logic [EW-1:0]   k;
  logic            shl;

  // Unbiased exponent and signed distance from the integer-aligned position.
  logic signed [EW-1:0] e_c, d_c;
  logic [EW-1:0]        k_abs;
  logic                 exp_zero, exp_ones, frac_zero;
  logic                 is_special;
  logic                 inc;
  logic [INTn-1:0]      rounded;

  always_comb begin
    e_c        = $signed({2'b00, exp_r}) - BIAS_W;
    d_c        = e_c - NSIG_W;
    k_abs      = d_c[EW-1] ? EW'(-d_c) : EW'(d_c);
    exp_zero   = (exp_r == '0);
    exp_ones   = (exp_r == '1);
    frac_zero  = (frac_r == '0);
    is_special = exp_zero || exp_ones || (e_c >= E_SAT) || (e_c <= E_LO);
    inc        = guard && (sticky || mag[0]);
    rounded    = mag + INTn'(inc);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (in_valid) state_nxt = CLASSIFY;
      CLASSIFY: begin
        if (is_special)      state_nxt = DONE;
        else if (k_abs == 0) state_nxt = ROUND;
        else                 state_nxt = ALIGN;
      end
      ALIGN:    if (k == EW'(1)) state_nxt = ROUND;
      ROUND:    state_nxt = DONE;
      DONE:     if (out_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_r  <= 1'b0;
      exp_r   <= '0;
      frac_r  <= '0;
      mag     <= '0;
      guard   <= 1'b0;
      sticky  <= 1'b0;
      k       <= '0;
      shl     <= 1'b0;
      out     <= '0;
      inexact <= 1'b0;
      invalid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign_r <= in[NEXP+NSIG];
          exp_r  <= in[NEXP+NSIG-1:NSIG];
          frac_r <= in[NSIG-1:0];
        end
        CLASSIFY: begin
          mag    <= {{(INTn-NSIG-1){1'b0}}, 1'b1, frac_r};
          guard  <= 1'b0;
          sticky <= 1'b0;
          k      <= k_abs;
          shl    <= !d_c[EW-1];
          if (exp_zero) begin
            // zero (either sign) is exact; subnormals flush to zero
            out     <= '0;
            inexact <= !frac_zero;
            invalid <= 1'b0;
          end else if (exp_ones && !frac_zero) begin
            out     <= INT_MAX;
            inexact <= 1'b0;
            invalid <= 1'b1;
          end else if (e_c >= E_SAT) begin
            // -2^(INTn-1) itself is representable and therefore not invalid
            out     <= sign_r ? INT_MIN : INT_MAX;
            inexact <= 1'b0;
            invalid <= !(sign_r && (e_c == E_SAT) && frac_zero);
          end else if (e_c <= E_LO) begin
            out     <= '0;
            inexact <= 1'b1;
            invalid <= 1'b0;
          end
        end
        ALIGN: begin
          k <= k - EW'(1);
          if (shl) begin
            mag <= {mag[INTn-2:0], 1'b0};
          end else begin
            mag    <= {1'b0, mag[INTn-1:1]};
            guard  <= mag[0];
            sticky <= sticky | guard;
          end
        end
        ROUND: begin
          out     <= sign_r ? (~rounded + INTn'(1)) : rounded;
          inexact <= guard | sticky;
          invalid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hp_cvtws_seq.sv
// tb/tb_hp_cvtws_seq.sv - directed self-checking bench for hp_cvtws_seq
module tb_hp_cvtws_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        inexact;
  logic        invalid;

  int n_cmp = 0;
  int n_bad = 0;

  hp_cvtws_seq #(.INTn(32), .NEXP(8), .NSIG(7)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .inexact(inexact), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operand and wait for the result; lat is the edge count after the capture edge.
  task automatic send(input logic [15:0] v, output int lat);
    @(negedge clk);
    in       = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
  endtask

  task automatic run(input string tag, input logic [15:0] v, input logic [31:0] e_out,
                     input logic e_inx, input logic e_inv, input int e_lat);
    int lat;
    send(v, lat);
    check({tag, " lat"}, 32'(lat), 32'(e_lat));
    check({tag, " out"}, out, e_out);
    check({tag, " inexact"}, {31'b0, inexact}, {31'b0, e_inx});
    check({tag, " invalid"}, {31'b0, invalid}, {31'b0, e_inv});
    @(posedge clk);
    #1 check({tag, " drop"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    logic        seen;
    rst = 1'b1; in_valid = 1'b0; in = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", {31'b0, in_ready}, 32'd1);
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst out", out, 32'd0);
    check("rst flags", {30'b0, inexact, invalid}, 32'd0);
    rst = 1'b0;

    run("1.5",    16'h3FC0, 32'd2,          1'b1, 1'b0, 9);
    run("0.75",   16'h3F40, 32'd1,          1'b1, 1'b0, 10);
    run("1.25",   16'h3FA0, 32'd1,          1'b1, 1'b0, 9);
    run("2.5",    16'h4020, 32'd2,          1'b1, 1'b0, 8);
    run("-2.5",   16'hC020, 32'hFFFFFFFE,   1'b1, 1'b0, 8);
    run("3.5",    16'h4060, 32'd4,          1'b1, 1'b0, 8);
    run("7",      16'h40E0, 32'd7,          1'b0, 1'b0, 7);
    run("-7",     16'hC0E0, 32'hFFFFFFF9,   1'b0, 1'b0, 7);
    run("128",    16'h4300, 32'd128,        1'b0, 1'b0, 2);
    run("255",    16'h437F, 32'd255,        1'b0, 1'b0, 2);
    run("2^23",   16'h4B00, 32'h00800000,   1'b0, 1'b0, 18);
    run("-2^31",  16'hCF00, 32'h80000000,   1'b0, 1'b0, 1);
    run("2^31",   16'h4F00, 32'h7FFFFFFF,   1'b0, 1'b1, 1);
    run("nan",    16'h7FC0, 32'h7FFFFFFF,   1'b0, 1'b1, 1);
    run("-inf",   16'hFF80, 32'h80000000,   1'b0, 1'b1, 1);
    run("+0",     16'h0000, 32'd0,          1'b0, 1'b0, 1);
    run("-0",     16'h8000, 32'd0,          1'b0, 1'b0, 1);
    run("0.5",    16'h3F00, 32'd0,          1'b1, 1'b0, 10);
    run("0.25",   16'h3E80, 32'd0,          1'b1, 1'b0, 1);
    run("subn",   16'h0001, 32'd0,          1'b1, 1'b0, 1);

    // backpressure: result held while out_ready is low
    out_ready = 1'b0;
    send(16'hC020, lat);
    check("bp lat", 32'(lat), 32'd8);
    held = out;
    check("bp out", held, 32'hFFFFFFFE);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp hold out", out, 32'hFFFFFFFE);
      check("bp hold valid", {31'b0, out_valid}, 32'd1);
      check("bp hold in_ready", {31'b0, in_ready}, 32'd0);
      check("bp hold inexact", {31'b0, inexact}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("bp release in_ready", {31'b0, in_ready}, 32'd1);

    // reset during ALIGN aborts the operation
    @(negedge clk);
    in = 16'h4B00; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort in_ready", {31'b0, in_ready}, 32'd1);
    check("abort out_valid", {31'b0, out_valid}, 32'd0);
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1'b1;
    end
    check("abort no result", {31'b0, seen}, 32'd0);
    run("post-rst 1.5", 16'h3FC0, 32'd2, 1'b1, 1'b0, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
